regfile_wb_arbiter: RTL and testbench

//  Shares the single register-file write port between the in-order pipeline

---
 rtl/regfile_wb_arbiter.sv | 153 +++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single RegFile write port between pipeline writeback and the MDU,
// tracks in-flight MDU destinations, and forces a pipeline bubble for a starving MDU result.
module regfile_wb_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int NREG       = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_dat,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_dat,
  output logic        mdu_ready,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  input  logic [4:0]  dec_ra,
  input  logic [4:0]  dec_rb,
  input  logic [4:0]  dec_rw,
  output logic        haz_a,
  output logic        haz_b,
  output logic        haz_w,
  output logic        stall_pipe,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdat
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] FORCE = 2'd2;
  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  logic [NREG-1:0] pend_r;
  logic [NREG-1:0] pend_nxt_s;
  logic [1:0]      state_r;
  logic [1:0]      state_nxt_s;
  logic [2:0]      cnt_r;
  logic [2:0]      cnt_nxt_s;
  logic [2:0]      cnt_inc_s;
  logic            stall_r;
  logic            wb_eff_s;
  logic            commit_s;

  assign wb_eff_s = wb_we & (wb_rd != 5'd0);
  assign commit_s = mdu_valid & mdu_ready;
  assign cnt_inc_s = (cnt_r == 3'd7) ? 3'd7 : cnt_r + 3'd1;

  // Write-port mux: WB always wins, MDU takes any slot WB leaves free.
  always_comb begin
    rf_we     = 1'b0;
    rf_waddr  = 5'd0;
    rf_wdat   = 32'd0;
    mdu_ready = 1'b0;
    if (rst) begin
      rf_we     = 1'b0;
      mdu_ready = 1'b0;
    end else if (wb_eff_s) begin
      rf_we    = 1'b1;
      rf_waddr = wb_rd;
      rf_wdat  = wb_dat;
    end else if (mdu_valid) begin
      // An MDU result for r0 still completes, it just never reaches the RegFile.
      rf_we     = (mdu_rd != 5'd0);
      rf_waddr  = mdu_rd;
      rf_wdat   = mdu_dat;
      mdu_ready = 1'b1;
    end else begin
      rf_we     = 1'b0;
      mdu_ready = 1'b0;
    end
  end

  // Scoreboard next state: issue set takes priority over a same-cycle commit clear.
  always_comb begin
    pend_nxt_s = pend_r;
    if (commit_s) begin
      pend_nxt_s[mdu_rd] = 1'b0;
    end else begin
      pend_nxt_s = pend_r;
    end
    if (iss_valid) begin
      pend_nxt_s[iss_rd] = 1'b1;
    end else begin
      pend_nxt_s[0] = 1'b0;
    end
    pend_nxt_s[0] = 1'b0;
  end

  // Starvation FSM next state and wait counter.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (mdu_valid & ~mdu_ready) begin
          state_nxt_s = WAIT;
          cnt_nxt_s   = 3'd1;
        end else begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = 3'd0;
        end
      end
      WAIT: begin
        if (commit_s) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = 3'd0;
        end else if (cnt_inc_s >= STARVE_LIM) begin
          state_nxt_s = FORCE;
          cnt_nxt_s   = cnt_inc_s;
        end else begin
          state_nxt_s = WAIT;
          cnt_nxt_s   = cnt_inc_s;
        end
      end
      FORCE: begin
        if (commit_s | ~mdu_valid) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = 3'd0;
        end else begin
          state_nxt_s = FORCE;
          cnt_nxt_s   = cnt_r;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 3'd0;
      end
    endcase
  end

  // State registers; stall_pipe is registered from the next state so it is a clean Moore output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_r  <= '0;
      state_r <= IDLE;
      cnt_r   <= 3'd0;
      stall_r <= 1'b0;
    end else begin
      pend_r  <= pend_nxt_s;
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      stall_r <= (state_nxt_s == FORCE);
    end
  end

  assign stall_pipe = stall_r;
  assign haz_a      = ~rst & pend_r[dec_ra];
  assign haz_b      = ~rst & pend_r[dec_rb];
  assign haz_w      = ~rst & pend_r[dec_rw];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter against a cycle-level behavioural model.
module tb_regfile_wb_arbiter;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_dat;
  logic        mdu_valid;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_dat;
  logic        mdu_ready;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [4:0]  dec_ra, dec_rb, dec_rw;
  logic        haz_a, haz_b, haz_w;
  logic        stall_pipe;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdat;

  int total = 0;
  int bad = 0;
  bit mpend[32];
  int streak;
  int issued, committed;
  logic [4:0] mq[$];

  regfile_wb_arbiter #(.STARVE_MAX(STARVE_MAX), .NREG(32)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_dat(wb_dat),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_dat(mdu_dat), .mdu_ready(mdu_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .dec_ra(dec_ra), .dec_rb(dec_rb), .dec_rw(dec_rw),
    .haz_a(haz_a), .haz_b(haz_b), .haz_w(haz_w),
    .stall_pipe(stall_pipe),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdat(rf_wdat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (mpend[i]) mpend[i] = 1'b0;
    streak = 0;
  endtask

  // Expected port behaviour from the arbitration rules and the model state.
  task automatic check_outputs();
    bit eff;
    #1;
    eff = wb_we && (wb_rd != 5'd0);
    chk("rf_we", 32'(rf_we), eff ? 32'd1 : (mdu_valid ? 32'(mdu_rd != 5'd0) : 32'd0));
    chk("rf_waddr", 32'(rf_waddr), eff ? 32'(wb_rd) : (mdu_valid ? 32'(mdu_rd) : 32'd0));
    chk("rf_wdat", rf_wdat, eff ? wb_dat : (mdu_valid ? mdu_dat : 32'd0));
    chk("mdu_ready", 32'(mdu_ready), 32'(!eff && mdu_valid));
    chk("stall_pipe", 32'(stall_pipe), 32'(streak >= STARVE_MAX));
    chk("haz_a", 32'(haz_a), 32'(mpend[dec_ra]));
    chk("haz_b", 32'(haz_b), 32'(mpend[dec_rb]));
    chk("haz_w", 32'(haz_w), 32'(mpend[dec_rw]));
  endtask

  // One clock: check current outputs, then advance the model across the edge.
  task automatic step();
    bit eff, commit;
    check_outputs();
    eff = wb_we && (wb_rd != 5'd0);
    commit = mdu_valid && !eff;
    @(posedge clk);
    if (commit) mpend[mdu_rd] = 1'b0;
    if (iss_valid && iss_rd != 5'd0) mpend[iss_rd] = 1'b1;
    streak = (commit || !mdu_valid) ? 0 : streak + 1;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    wb_we = 1'b0; wb_rd = 5'd0; wb_dat = 32'd0;
    mdu_valid = 1'b0; mdu_rd = 5'd0; mdu_dat = 32'd0;
    iss_valid = 1'b0; iss_rd = 5'd0;
    dec_ra = 5'd0; dec_rb = 5'd0; dec_rw = 5'd0;
  endtask

  initial begin
    bit obs_commit;
    int guard;
    idle_inputs();
    model_reset();
    rst = 1'b1;
    wb_we = 1'b1; wb_rd = 5'd3; wb_dat = 32'h1234_5678; mdu_valid = 1'b1; mdu_rd = 5'd4;
    #1;
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_mdu_ready", 32'(mdu_ready), 32'd0);
    chk("rst_stall", 32'(stall_pipe), 32'd0);
    @(negedge clk); @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    step();

    // Starve the MDU into FORCE, then reset asynchronously mid-FORCE.
    wb_we = 1'b1; wb_rd = 5'd1; wb_dat = 32'hDEAD_0001;
    mdu_valid = 1'b1; mdu_rd = 5'd2; mdu_dat = 32'h0000_0222;
    iss_valid = 1'b1; iss_rd = 5'd9; dec_ra = 5'd9;
    step();
    iss_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    #1;
    chk("t1_stall_pre", 32'(stall_pipe), 32'd1);
    chk("t1_haz_pre", 32'(haz_a), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("t1_stall_rst", 32'(stall_pipe), 32'd0);
    chk("t1_rf_we_rst", 32'(rf_we), 32'd0);
    chk("t1_ready_rst", 32'(mdu_ready), 32'd0);
    chk("t1_haz_rst", 32'(haz_a), 32'd0);
    @(negedge clk);
    idle_inputs();
    dec_ra = 5'd9;
    rst = 1'b0;
    model_reset();
    #1;
    chk("t1_pend_clr", 32'(haz_a), 32'd0);
    step();

    // WB wins the port, MDU takes it next cycle.
    wb_we = 1'b1; wb_rd = 5'd5; wb_dat = 32'hA5A5_A5A5;
    mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_dat = 32'h7777_0007;
    #1;
    chk("t2_waddr_wb", 32'(rf_waddr), 32'd5);
    chk("t2_wdat_wb", rf_wdat, 32'hA5A5_A5A5);
    chk("t2_ready_wb", 32'(mdu_ready), 32'd0);
    step();
    wb_we = 1'b0;
    #1;
    chk("t2_waddr_mdu", 32'(rf_waddr), 32'd7);
    chk("t2_ready_mdu", 32'(mdu_ready), 32'd1);
    step();
    mdu_valid = 1'b0;

    // Scoreboard set, clear, and set-wins-over-clear.
    iss_valid = 1'b1; iss_rd = 5'd9;
    step();
    iss_valid = 1'b0; dec_ra = 5'd9;
    #1 chk("t3_haz_set", 32'(haz_a), 32'd1);
    mdu_valid = 1'b1; mdu_rd = 5'd9; mdu_dat = 32'h0000_0009;
    step();
    mdu_valid = 1'b0;
    #1 chk("t3_haz_clr", 32'(haz_a), 32'd0);
    iss_valid = 1'b1; iss_rd = 5'd9;
    step();
    mdu_valid = 1'b1; mdu_rd = 5'd9;
    step();
    iss_valid = 1'b0; mdu_valid = 1'b0;
    #1 chk("t3_haz_setwins", 32'(haz_a), 32'd1);
    mdu_valid = 1'b1;
    step();
    mdu_valid = 1'b0;
    #1 chk("t3_haz_final", 32'(haz_a), 32'd0);

    // Continuous WB traffic starves the MDU until stall_pipe opens a slot.
    wb_we = 1'b1; wb_rd = 5'd4; wb_dat = 32'h4444_4444;
    mdu_valid = 1'b1; mdu_rd = 5'd6; mdu_dat = 32'h6666_6666;
    for (int i = 0; i < 5; i++) begin
      #1 chk("t4_stall_seq", 32'(stall_pipe), 32'(i >= STARVE_MAX));
      if (i < 4) step();
    end
    wb_we = 1'b0;
    #1 chk("t4_ready", 32'(mdu_ready), 32'd1);
    step();
    mdu_valid = 1'b0;
    #1 chk("t4_stall_off", 32'(stall_pipe), 32'd0);

    // r0 writes: WB to r0 yields the port, MDU to r0 completes without a write.
    wb_we = 1'b1; wb_rd = 5'd0; wb_dat = 32'hFFFF_FFFF;
    mdu_valid = 1'b1; mdu_rd = 5'd3; mdu_dat = 32'h3333_3333;
    #1;
    chk("t5_waddr", 32'(rf_waddr), 32'd3);
    chk("t5_ready", 32'(mdu_ready), 32'd1);
    step();
    wb_we = 1'b0; mdu_rd = 5'd0;
    #1;
    chk("t5_r0_we", 32'(rf_we), 32'd0);
    chk("t5_r0_ready", 32'(mdu_ready), 32'd1);
    step();
    idle_inputs();
    step();

    // Random traffic: the MDU holds each result until the DUT accepts it.
    issued = 0; committed = 0; obs_commit = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (obs_commit) mdu_valid = 1'b0;
      if (!mdu_valid && mq.size() > 0 && $urandom_range(0, 2) == 0) begin
        mdu_valid = 1'b1;
        mdu_rd = mq.pop_front();
        mdu_dat = $urandom;
      end
      wb_we = (streak >= STARVE_MAX) ? 1'b0 : ($urandom_range(0, 9) < 7);
      wb_rd = 5'($urandom_range(0, 31));
      wb_dat = $urandom;
      iss_valid = (c < 500) && ($urandom_range(0, 3) == 0);
      iss_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      if (iss_valid) begin
        mq.push_back(iss_rd);
        issued++;
      end
      dec_ra = 5'($urandom_range(0, 31));
      dec_rb = 5'($urandom_range(0, 31));
      dec_rw = iss_rd;
      #1 obs_commit = mdu_valid && mdu_ready;
      if (obs_commit) committed++;
      step();
    end
    // Drain remaining results with the issue side quiet.
    iss_valid = 1'b0;
    guard = 0;
    while ((mq.size() > 0 || mdu_valid) && guard < 400) begin
      if (obs_commit) mdu_valid = 1'b0;
      if (!mdu_valid && mq.size() > 0) begin
        mdu_valid = 1'b1;
        mdu_rd = mq.pop_front();
        mdu_dat = $urandom;
      end
      wb_we = (streak >= STARVE_MAX) ? 1'b0 : ($urandom_range(0, 1) == 0);
      wb_rd = 5'($urandom_range(0, 31));
      obs_commit = 1'b0;
      if (mdu_valid) begin
        #1 obs_commit = mdu_valid && mdu_ready;
        if (obs_commit) committed++;
      end
      step();
      if (obs_commit) mdu_valid = 1'b0;
      obs_commit = 1'b0;
      guard++;
    end
    chk("drain_left", 32'(mq.size()) + 32'(mdu_valid), 32'd0);
    chk("commit_count", 32'(committed), 32'(issued));
    for (int r = 0; r < 32; r++) begin
      dec_ra = 5'(r);
      #1 chk("final_pend", 32'(haz_a), 32'(mpend[r]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
